// File: rtl/fft_bfly_sequencer.sv
// Address/control sequencer for an in-place radix-2 DIT FFT over a dual-port
// complex sample RAM: read slots on even cycles, delayed write-backs on odd cycles.
module fft_bfly_sequencer #(
  parameter int LOG2N    = 10,
  parameter int PIPE_DLY = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [LOG2N-1:0] address_a_out,
  output logic [LOG2N-1:0] address_b_out,
  output logic             wren,
  output logic             rd_valid,
  output logic [LOG2N-2:0] twiddle_addr,
  output logic [3:0]       stage_out,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(PIPE_DLY);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           r_state, w_nState;
  logic [3:0]       r_stage, w_nStage;
  logic [LOG2N-2:0] r_bfly, w_nBfly;
  logic             r_phase, w_nPhase;
  logic [CW-1:0]    r_cnt, w_nCnt;
  logic             w_nRead, w_nBusy, w_nDone;

  logic [LOG2N-2:0] w_mask, w_idx, w_grp, w_tw;
  logic [LOG2N-1:0] w_span, w_addrA, w_addrB, w_outA, w_outB;

  logic             r_dlValid [PIPE_DLY];
  logic [LOG2N-1:0] r_dlA     [PIPE_DLY];
  logic [LOG2N-1:0] r_dlB     [PIPE_DLY];

  // Next-cycle control; all outputs are registered from these next values.
  always_comb begin
    w_nState = r_state;
    w_nStage = r_stage;
    w_nBfly  = r_bfly;
    w_nPhase = r_phase;
    w_nCnt   = r_cnt;
    w_nRead  = 1'b0;
    w_nBusy  = 1'b0;
    w_nDone  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_nState = RUN;
          w_nStage = '0;
          w_nBfly  = '0;
          w_nPhase = 1'b0;
          w_nRead  = 1'b1;
          w_nBusy  = 1'b1;
        end
      end
      RUN: begin
        w_nBusy = 1'b1;
        if (!r_phase) begin
          w_nPhase = 1'b1;
          w_nBfly  = r_bfly + 1'b1;
          if (r_bfly == '1) begin
            w_nState = DRAIN;
            w_nCnt   = '0;
          end
        end else begin
          w_nPhase = 1'b0;
          w_nRead  = 1'b1;
        end
      end
      DRAIN: begin
        w_nBusy = 1'b1;
        if (r_cnt == CW'(PIPE_DLY - 1)) begin
          if (r_stage == 4'(LOG2N - 1)) begin
            w_nState = DONE;
            w_nBusy  = 1'b0;
            w_nDone  = 1'b1;
          end else begin
            w_nState = RUN;
            w_nStage = r_stage + 4'd1;
            w_nBfly  = '0;
            w_nPhase = 1'b0;
            w_nRead  = 1'b1;
          end
        end else begin
          w_nCnt = r_cnt + 1'b1;
        end
      end
      DONE: w_nState = IDLE;
      default: w_nState = IDLE;
    endcase
  end

  // Butterfly pair and twiddle index for the upcoming read slot.
  always_comb begin
    w_mask  = ~({(LOG2N-1){1'b1}} << w_nStage);
    w_idx   = w_nBfly & w_mask;
    w_grp   = w_nBfly >> w_nStage;
    w_span  = {{(LOG2N-1){1'b0}}, 1'b1} << w_nStage;
    w_addrA = ({1'b0, w_grp} << (w_nStage + 4'd1)) | {1'b0, w_idx};
    w_addrB = w_addrA + w_span;
    w_tw    = w_idx << (4'(LOG2N - 1) - w_nStage);
    w_outA  = '0;
    w_outB  = '0;
    if (w_nRead) begin
      w_outA = w_addrA;
      w_outB = w_addrB;
    end else if (r_dlValid[PIPE_DLY-1]) begin
      w_outA = r_dlA[PIPE_DLY-1];
      w_outB = r_dlB[PIPE_DLY-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_stage       <= '0;
      r_bfly        <= '0;
      r_phase       <= 1'b0;
      r_cnt         <= '0;
      address_a_out <= '0;
      address_b_out <= '0;
      wren          <= 1'b0;
      rd_valid      <= 1'b0;
      twiddle_addr  <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      for (int i = 0; i < PIPE_DLY; i++) begin
        r_dlValid[i] <= 1'b0;
        r_dlA[i]     <= '0;
        r_dlB[i]     <= '0;
      end
    end else begin
      r_state       <= w_nState;
      r_stage       <= w_nStage;
      r_bfly        <= w_nBfly;
      r_phase       <= w_nPhase;
      r_cnt         <= w_nCnt;
      address_a_out <= w_outA;
      address_b_out <= w_outB;
      wren          <= r_dlValid[PIPE_DLY-1];
      rd_valid      <= w_nRead;
      twiddle_addr  <= w_nRead ? w_tw : '0;
      busy          <= w_nBusy;
      done          <= w_nDone;
      // Odd delay guarantees the write lands on the opposite slot parity.
      r_dlValid[0] <= w_nRead;
      r_dlA[0]     <= w_addrA;
      r_dlB[0]     <= w_addrB;
      for (int i = 1; i < PIPE_DLY; i++) begin
        r_dlValid[i] <= r_dlValid[i-1];
        r_dlA[i]     <= r_dlA[i-1];
        r_dlB[i]     <= r_dlB[i-1];
      end
    end
  end

  assign stage_out = r_stage;

endmodule

// File: tb/tb_fft_bfly_sequencer.sv
// Directed bench for fft_bfly_sequencer at N=8, PIPE_DLY=5 using a per-cycle
// table of hand-computed read/write slots.
module tb_fft_bfly_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] address_a_out, address_b_out;
  logic       wren, rd_valid, busy, done;
  logic [1:0] twiddle_addr;
  logic [3:0] stage_out;

  int testsRun = 0;
  int failures = 0;

  fft_bfly_sequencer #(.LOG2N(3), .PIPE_DLY(5)) dut (
    .clk(clk), .rst(rst), .start(start),
    .address_a_out(address_a_out), .address_b_out(address_b_out),
    .wren(wren), .rd_valid(rd_valid), .twiddle_addr(twiddle_addr),
    .stage_out(stage_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic       rd;
    logic [2:0] a;
    logic [2:0] b;
    logic [1:0] tw;
    logic [3:0] stg;
  } vec_t;

  vec_t vecs[24];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Start pulse sampled on the next edge; returns at the sample point of cycle 0.
  task automatic applyStimulus();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  function automatic logic [15:0] expVec(input int k);
    logic [15:0] v;
    v = {(k < 36), (k == 36), 14'd0};
    foreach (vecs[i]) begin
      if (vecs[i].cyc == k) begin
        v[13] = vecs[i].rd;
        v[12] = !vecs[i].rd;
        v[11:9] = vecs[i].a;
        v[8:6] = vecs[i].b;
        v[5:4] = vecs[i].rd ? vecs[i].tw : 2'd0;
        v[3:0] = vecs[i].rd ? vecs[i].stg : 4'd0;
      end
    end
    return v;
  endfunction

  function automatic logic [15:0] actVec();
    return {busy, done, rd_valid, wren, address_a_out, address_b_out,
            rd_valid ? twiddle_addr : 2'd0, rd_valid ? stage_out : 4'd0};
  endfunction

  task automatic runFft(input bit busyStart, input int stopAt);
    int lastWr = -1;
    int prevStg = -1;
    applyStimulus();
    for (int k = 0; k <= 36; k++) begin
      checkOutput($sformatf("cyc%0d", k), 32'(actVec()), 32'(expVec(k)));
      checkOutput($sformatf("excl%0d", k), 32'(rd_valid && wren), 32'd0);
      if (rd_valid && (int'(stage_out) != prevStg)) begin
        checkOutput($sformatf("hazard_stg%0d", stage_out), 32'(k > lastWr), 32'd1);
        prevStg = int'(stage_out);
      end
      if (wren) lastWr = k;
      if (k == stopAt) begin
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_mid", 32'({busy, done, rd_valid, wren}), 32'd0);
        rst = 1'b0;
        for (int j = 0; j < 20; j++) begin
          @(negedge clk);
          checkOutput($sformatf("post_rst%0d", j), 32'({busy, wren, rd_valid, done}), 32'd0);
        end
        return;
      end
      if (busyStart && k == 10) start = 1'b1;
      if (busyStart && k == 11) start = 1'b0;
      @(negedge clk);
    end
    for (int j = 0; j < 4; j++) begin
      checkOutput($sformatf("after_done%0d", j), 32'({busy, done, rd_valid, wren}), 32'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    vecs = '{
      '{ 0, 1'b1, 3'd0, 3'd1, 2'd0, 4'd0}, '{ 2, 1'b1, 3'd2, 3'd3, 2'd0, 4'd0},
      '{ 4, 1'b1, 3'd4, 3'd5, 2'd0, 4'd0}, '{ 6, 1'b1, 3'd6, 3'd7, 2'd0, 4'd0},
      '{ 5, 1'b0, 3'd0, 3'd1, 2'd0, 4'd0}, '{ 7, 1'b0, 3'd2, 3'd3, 2'd0, 4'd0},
      '{ 9, 1'b0, 3'd4, 3'd5, 2'd0, 4'd0}, '{11, 1'b0, 3'd6, 3'd7, 2'd0, 4'd0},
      '{12, 1'b1, 3'd0, 3'd2, 2'd0, 4'd1}, '{14, 1'b1, 3'd1, 3'd3, 2'd2, 4'd1},
      '{16, 1'b1, 3'd4, 3'd6, 2'd0, 4'd1}, '{18, 1'b1, 3'd5, 3'd7, 2'd2, 4'd1},
      '{17, 1'b0, 3'd0, 3'd2, 2'd0, 4'd0}, '{19, 1'b0, 3'd1, 3'd3, 2'd0, 4'd0},
      '{21, 1'b0, 3'd4, 3'd6, 2'd0, 4'd0}, '{23, 1'b0, 3'd5, 3'd7, 2'd0, 4'd0},
      '{24, 1'b1, 3'd0, 3'd4, 2'd0, 4'd2}, '{26, 1'b1, 3'd1, 3'd5, 2'd1, 4'd2},
      '{28, 1'b1, 3'd2, 3'd6, 2'd2, 4'd2}, '{30, 1'b1, 3'd3, 3'd7, 2'd3, 4'd2},
      '{29, 1'b0, 3'd0, 3'd4, 2'd0, 4'd0}, '{31, 1'b0, 3'd1, 3'd5, 2'd0, 4'd0},
      '{33, 1'b0, 3'd2, 3'd6, 2'd0, 4'd0}, '{35, 1'b0, 3'd3, 3'd7, 2'd0, 4'd0}
    };

    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_state", 32'(actVec()), 32'd0);
    rst = 1'b0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      checkOutput($sformatf("idle%0d", j), 32'(actVec()), 32'd0);
    end

    runFft(1'b0, -1);
    runFft(1'b1, -1);
    runFft(1'b0, -1);
    runFft(1'b0, 14);
    runFft(1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule

// File: doc/fft_bfly_sequencer.md
Name: fft_bfly_sequencer

Overview:
- Sequences an in-place radix-2 DIT FFT over the complex dual-port sample RAM (real/imag banks sharing address_a, address_b and a single wren).
- The RAM ports are shared between butterfly reads and write-backs, so the block time-multiplexes them:
  - even slots read a butterfly pair;
  - odd slots write back the pair read PIPE_DLY cycles earlier.
- The block also issues twiddle ROM addresses and inserts a drain between stages to avoid read-after-write hazards.
- Input samples must already be in bit-reversed order in RAM.

Parameters:
- LOG2N, 10, log2 of FFT size N; the RAM address width.
- PIPE_DLY, 5, cycles from read slot to write slot of the same butterfly (RAM read latency + butterfly latency); must be odd and >= 3.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle request to run a full FFT; ignored unless idle
- address_a_out  out  LOG2N  RAM port A address (top/even element)
- address_b_out  out  LOG2N  RAM port B address (bottom/odd element)
- wren  out  1  write enable for both ports and both banks
- rd_valid  out  1  high on read slots; tags the pair entering the butterfly datapath
- twiddle_addr  out  LOG2N-1  twiddle ROM index, valid with rd_valid
- stage_out  out  4  current stage index 0..LOG2N-1
- busy  out  1  FFT in progress
- done  out  1  one-cycle pulse after the final write

Behaviour:
- All outputs registered. Reset values:
  - all addresses 0, twiddle_addr 0, stage_out 0;
  - wren, rd_valid, busy and done all 0;
  - FSM in IDLE, delay line cleared.
- FSM states and transitions:
  - IDLE: start=1 -> RUN; stage=0, bfly=0, phase=0.
  - RUN: phase toggles every cycle.
    - phase 0 (read slot): rd_valid=1 and addresses = pair(stage, bfly); push {addr_a, addr_b} into the PIPE_DLY-deep delay line; bfly++.
    - After bfly N/2-1 is issued -> DRAIN.
  - DRAIN: no new reads; continue draining the delay line until the last write of the stage has been issued.
    - Next cycle -> RUN with stage+1 and bfly=0, or -> DONE if stage = LOG2N-1.
  - DONE: done=1 and busy=0 for one cycle -> IDLE.
- Write slots:
  - When the delay-line output is valid, drive wren=1 and the delayed addresses.
  - Because PIPE_DLY is odd, writes always land on odd slots and never collide with reads.
  - rd_valid and wren are never both 1.
- Idle slots (neither read nor write): addresses 0, wren 0, rd_valid 0.
- Address generation, with span = 2^stage, grp = bfly >> stage, idx = bfly & (span-1):
  - addr_a = (grp << (stage+1)) | idx
  - addr_b = addr_a + span
  - twiddle_addr = idx << (LOG2N-1-stage)
  - All arithmetic is unsigned at LOG2N bits; no overflow is possible.
- Timing per stage, with cycle 0 = first busy cycle:
  - reads at 0, 2, ..., N-2;
  - last write at N-2+PIPE_DLY;
  - next stage's first read at N-1+PIPE_DLY;
  - stage length N-1+PIPE_DLY cycles; busy is high for LOG2N*(N-1+PIPE_DLY) cycles.
- busy rises the cycle after start is sampled. start while busy or in DONE has no effect.
- Reset mid-run: next edge returns to IDLE, wren=0, and pending writes are discarded. The RAM contents are then undefined for the FFT; software must restart.
- stage_out tracks the stage of read slots and holds through DRAIN.

Test Plan:
- Reset then idle, LOG2N=3, PIPE_DLY=5: rst held 3 cycles, start=0 -> all outputs 0, busy 0 for 20 cycles.
- Stage 0 addressing (N=8): pulse start -> rd_valid at cycles 0, 2, 4, 6 with pairs (0,1), (2,3), (4,5), (6,7), twiddle 0 each; wren at 5, 7, 9, 11 with the same pairs in order.
- Stages 1 and 2 (N=8):
  - stage 1 first read at cycle 12: pairs (0,2), (1,3), (4,6), (5,7), twiddles 0, 2, 0, 2.
  - stage 2 first read at cycle 24: pairs (0,4), (1,5), (2,6), (3,7), twiddles 0, 1, 2, 3.
  - done pulses at cycle 36; busy high for exactly 36 cycles.
- Port exclusivity and hazards: over a full run, assert !(wren && rd_valid) every cycle, and every stage's first read cycle > previous stage's last wren cycle.
- Start while busy: second start pulse at cycle 10 -> no effect; single done at cycle 36; a fresh start after done repeats an identical sequence.
- Reset mid-run: assert rst at cycle 14 (stage 1, writes pending) -> next cycle wren=0, busy=0, no further writes; start afterwards begins again at stage 0 pair (0,1).
